// File: rtl/occupancy_monitor_if.sv
// Beat/result bundle between the door-event collectors and occupancy_monitor.
// The collector side drives beats and clear; the monitor drives counts and fault diagnostics.
interface occupancy_monitor_if #(
   parameter int NDOORS  = 2,
   parameter int NROOMS  = 2,
   parameter int WORDLEN = 8
);
   localparam int RIDX = (NROOMS > 1) ? $clog2(NROOMS) : 1;

   logic                              in_valid;
   logic [2*WORDLEN*NROOMS*NDOORS-1:0] system;
   logic                              clear;
   logic [WORDLEN*NROOMS-1:0]         counts;
   logic                              out_valid;
   logic                              fault;
   logic [1:0]                        fault_kind;
   logic [RIDX-1:0]                   fault_room;

   modport master (
      output in_valid, system, clear,
      input  counts, out_valid, fault, fault_kind, fault_room
   );

   modport slave (
      input  in_valid, system, clear,
      output counts, out_valid, fault, fault_kind, fault_room
   );
endinterface

// File: rtl/occupancy_monitor.sv
// Clocked occupancy tracker: applies per-door entered/exited deltas to every room each beat,
// rejecting the whole beat on a range or ordering violation and latching the first fault.
module occupancy_monitor #(
   parameter int NDOORS        = 2,
   parameter int NROOMS        = 2,
   parameter int WORDLEN       = 8,
   parameter bit HALT_ON_FAULT = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   occupancy_monitor_if.slave   bus
);
   localparam int RIDX   = (NROOMS > 1) ? $clog2(NROOMS) : 1;
   // Two guard bits plus door-count growth keep every candidate exact: no wrap before the range test.
   localparam int SW     = WORDLEN + $clog2(NDOORS) + 2;
   localparam int BEAT_W = 2 * WORDLEN * NROOMS;

   typedef enum logic [1:0] {
      KIND_NONE  = 2'b00,
      KIND_ORDER = 2'b01,
      KIND_RANGE = 2'b10
   } fault_kind_e;

   typedef logic signed [SW-1:0] cand_t;

   logic [NROOMS-1:0][WORDLEN-1:0] r_counts;
   logic                           r_out_valid;
   logic                           r_fault;
   fault_kind_e                    r_fault_kind;
   logic [RIDX-1:0]                r_fault_room;

   cand_t                          w_cand [NROOMS];
   logic [NROOMS-1:0]              w_range_bad;
   logic [NROOMS-1:0]              w_order_bad;
   logic [RIDX-1:0]                w_range_room;
   logic [RIDX-1:0]                w_order_room;
   logic                           w_range_fault;
   logic                           w_order_fault;
   logic                           w_any_fault;
   fault_kind_e                    w_fault_kind;
   logic [RIDX-1:0]                w_fault_room;
   logic                           w_accept;
   logic                           w_first_fault;

   // Candidate count per room: current count plus all entered minus all exited, in signed arithmetic.
   always_comb begin
      for (int r = 0; r < NROOMS; r++) begin
         w_cand[r] = $signed({{(SW-WORDLEN){1'b0}}, r_counts[r]});
         for (int d = 0; d < NDOORS; d++) begin
            w_cand[r] = w_cand[r]
                      + $signed({{(SW-WORDLEN){1'b0}},
                                 bus.system[d*BEAT_W + r*2*WORDLEN + WORDLEN +: WORDLEN]})
                      - $signed({{(SW-WORDLEN){1'b0}},
                                 bus.system[d*BEAT_W + r*2*WORDLEN +: WORDLEN]});
         end
      end
   end

   // Range: negative, or any bit set above the count width. Order: a room holds fewer than the next one.
   always_comb begin
      w_range_bad = '0;
      w_order_bad = '0;
      for (int r = 0; r < NROOMS; r++) begin
         w_range_bad[r] = w_cand[r][SW-1] | (|w_cand[r][SW-2:WORDLEN]);
      end
      for (int r = 0; r < NROOMS - 1; r++) begin
         w_order_bad[r] = (w_cand[r] < w_cand[r+1]);
      end
   end

   // Scanning from the top down leaves the lowest failing room as the final assignment.
   always_comb begin
      w_range_room = '0;
      w_order_room = '0;
      for (int r = NROOMS - 1; r >= 0; r--) begin
         if (w_range_bad[r]) w_range_room = RIDX'(r);
         if (w_order_bad[r]) w_order_room = RIDX'(r);
      end
   end

   always_comb begin
      w_range_fault = |w_range_bad;
      w_order_fault = |w_order_bad;
      w_any_fault   = w_range_fault | w_order_fault;
      w_fault_kind  = KIND_NONE;
      w_fault_room  = '0;
      if (w_range_fault) begin
         w_fault_kind = KIND_RANGE;
         w_fault_room = w_range_room;
      end else if (w_order_fault) begin
         w_fault_kind = KIND_ORDER;
         w_fault_room = w_order_room;
      end
   end

   // A pending clear re-opens acceptance and lets this beat's fault become the recorded first fault.
   always_comb begin
      w_accept      = bus.in_valid && (!r_fault || !HALT_ON_FAULT || bus.clear);
      w_first_fault = !r_fault || bus.clear;
   end

   // NOTE: non-blocking assignments here; a later assignment in the same block wins, so the
   // fault-recording branch below deliberately overrides the clear that precedes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_counts     <= '0;
         r_out_valid  <= 1'b0;
         r_fault      <= 1'b0;
         r_fault_kind <= KIND_NONE;
         r_fault_room <= '0;
      end else begin
         r_out_valid <= w_accept;
         if (bus.clear) begin
            r_fault      <= 1'b0;
            r_fault_kind <= KIND_NONE;
            r_fault_room <= '0;
         end
         if (w_accept) begin
            if (w_any_fault) begin
               r_fault <= 1'b1;
               if (w_first_fault) begin
                  r_fault_kind <= w_fault_kind;
                  r_fault_room <= w_fault_room;
               end
            end else begin
               for (int r = 0; r < NROOMS; r++) begin
                  r_counts[r] <= w_cand[r][WORDLEN-1:0];
               end
            end
         end
      end
   end

   assign bus.counts     = r_counts;
   assign bus.out_valid  = r_out_valid;
   assign bus.fault      = r_fault;
   assign bus.fault_kind = r_fault_kind;
   assign bus.fault_room = r_fault_room;

endmodule
